// File: rtl/ov_capture_win.sv
// DVP camera capture: crops a pixel window out of decimated frames and assembles BPP bytes per pixel.
// PIX_VALID lands two OV_PCLK cycles after the last pixel byte on OV_DVP; sensor-paced, no backpressure.
module ov_capture_win #(
  parameter int DVP_W  = 8,
  parameter int BPP    = 2,
  parameter int X_W    = 12,
  parameter int Y_W    = 11,
  parameter int SKIP_W = 4
) (
  input  logic                 OV_PCLK,
  input  logic                 RST,
  input  logic [DVP_W-1:0]     OV_DVP,
  input  logic                 OV_HREF,
  input  logic                 OV_VSYNC,
  input  logic                 CFG_EN,
  input  logic [X_W-1:0]       CFG_X0,
  input  logic [Y_W-1:0]       CFG_Y0,
  input  logic [X_W-1:0]       CFG_W,
  input  logic [Y_W-1:0]       CFG_H,
  input  logic [SKIP_W-1:0]    CFG_SKIP,
  output logic [BPP*DVP_W-1:0] PIX_DATA,
  output logic                 PIX_VALID,
  output logic                 PIX_SOF,
  output logic                 PIX_EOL,
  output logic                 FRAME_DONE,
  output logic                 LINE_ERR,
  output logic [X_W-1:0]       X_CONT,
  output logic [Y_W-1:0]       Y_CONT,
  output logic [15:0]          FRAME_CNT
);

  typedef enum logic [1:0] {IDLE, ARM, CAPT, SKIP} state_t;

  localparam int PH_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BPP - 1);

  state_t state, state_n;
  logic   capt;

  logic [DVP_W-1:0]     dvp_s1;
  logic                 href_s1, vsync_s1, href_d, vsync_d;
  logic                 fs, fe, href_fall;
  logic [PH_W-1:0]      phase;
  logic                 pix_done;
  logic [BPP*DVP_W-1:0] pix_asm;

  logic [X_W-1:0]       x0_l, w_l;
  logic [Y_W-1:0]       y0_l, h_l;
  logic [SKIP_W-1:0]    skip_cnt;
  logic [X_W:0]         x_end, x_ext;
  logic [Y_W:0]         y_end, y_ext;
  logic                 x_in, y_in, x_last, emit, pix_seen, frame_end;

  always_ff @(posedge OV_PCLK) begin
    if (RST) begin
      dvp_s1   <= '0;
      href_s1  <= 1'b0;
      vsync_s1 <= 1'b0;
      href_d   <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      dvp_s1   <= OV_DVP;
      href_s1  <= OV_HREF;
      vsync_s1 <= OV_VSYNC;
      href_d   <= href_s1;
      vsync_d  <= vsync_s1;
    end
  end

  assign fs        = vsync_d & ~vsync_s1;
  assign fe        = ~vsync_d & vsync_s1;
  assign href_fall = href_d & ~href_s1;
  assign pix_done  = href_s1 && (phase == PH_LAST);

  always_ff @(posedge OV_PCLK) begin
    if (RST || !href_s1)
      phase <= '0;
    else
      phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  end

  // Earlier bytes of the pixel are held so the first byte ends up in the MSBs.
  generate
    if (BPP == 1) begin : g_single
      assign pix_asm = dvp_s1;
    end else begin : g_multi
      logic [(BPP-1)*DVP_W-1:0] hold;
      always_ff @(posedge OV_PCLK) begin
        if (RST) hold <= '0;
        else     hold <= pix_asm[(BPP-1)*DVP_W-1:0];
      end
      assign pix_asm = {hold, dvp_s1};
    end
  endgenerate

  always_ff @(posedge OV_PCLK) begin
    if (RST || !href_s1)  X_CONT <= '0;
    else if (pix_done)    X_CONT <= X_CONT + X_W'(1);
  end

  always_ff @(posedge OV_PCLK) begin
    if (RST || vsync_s1)  Y_CONT <= '0;
    else if (href_fall)   Y_CONT <= Y_CONT + Y_W'(1);
  end

  always_ff @(posedge OV_PCLK) begin
    if (RST) begin
      x0_l     <= '0;
      y0_l     <= '0;
      w_l      <= '0;
      h_l      <= '0;
      skip_cnt <= '0;
    end else if (fs) begin
      x0_l     <= CFG_X0;
      y0_l     <= CFG_Y0;
      w_l      <= CFG_W;
      h_l      <= CFG_H;
      skip_cnt <= (skip_cnt == '0) ? CFG_SKIP : skip_cnt - SKIP_W'(1);
    end
  end

  always_ff @(posedge OV_PCLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!CFG_EN && vsync_s1) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:       if (CFG_EN) state_n = ARM;
        ARM:        if (fs && CFG_EN) state_n = (skip_cnt == '0) ? CAPT : SKIP;
        CAPT, SKIP: if (fe) state_n = ARM;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    capt = 1'b0;
    case (state)
      CAPT:    capt = 1'b1;
      default: capt = 1'b0;
    endcase
  end

  // One extra bit keeps x0+w and y0+h from wrapping.
  assign x_ext  = {1'b0, X_CONT};
  assign y_ext  = {1'b0, Y_CONT};
  assign x_end  = {1'b0, x0_l} + {1'b0, w_l};
  assign y_end  = {1'b0, y0_l} + {1'b0, h_l};
  assign x_in   = (x_ext >= {1'b0, x0_l}) && (x_ext < x_end);
  assign y_in   = (y_ext >= {1'b0, y0_l}) && (y_ext < y_end);
  assign x_last = (x_ext + (X_W+1)'(1)) == x_end;
  assign emit   = pix_done && x_in && y_in && capt;

  assign frame_end = capt && fe && pix_seen;

  always_ff @(posedge OV_PCLK) begin
    if (RST) begin
      PIX_DATA   <= '0;
      PIX_VALID  <= 1'b0;
      PIX_SOF    <= 1'b0;
      PIX_EOL    <= 1'b0;
      pix_seen   <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      LINE_ERR   <= 1'b0;
    end else begin
      PIX_VALID  <= emit;
      PIX_SOF    <= emit && !pix_seen;
      PIX_EOL    <= emit && x_last;
      if (emit) PIX_DATA <= pix_asm;
      if (fs)        pix_seen <= 1'b0;
      else if (emit) pix_seen <= 1'b1;
      FRAME_DONE <= frame_end;
      if (frame_end) FRAME_CNT <= FRAME_CNT + 16'd1;
      if (href_fall && phase != '0) LINE_ERR <= 1'b1;
    end
  end

endmodule

// File: doc/ov_capture_win.md
OV_CAPTURE_WIN -- requirements
Module: ov_capture_win

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DVP_W, 8, sensor data bus width.
- BPP, 2, bytes per pixel; legal values are 1 (RAW8/mono) and 2 (RGB565/YUV422).
- X_W, 12, column counter/config width.
- Y_W, 11, row counter/config width.
- SKIP_W, 4, frame-decimation config width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- OV_PCLK, in, 1, sensor pixel clock; the only clock.
- RST, in, 1, synchronous active-high reset.
- OV_DVP, in, DVP_W, sensor data.
- OV_HREF, in, 1, line valid, active high.
- OV_VSYNC, in, 1, frame blanking, active high.
- CFG_EN, in, 1, capture enable.
- CFG_X0, in, X_W, window first column, in pixels.
- CFG_Y0, in, Y_W, window first row.
- CFG_W, in, X_W, window width; 0 means no pixels.
- CFG_H, in, Y_W, window height; 0 means no pixels.
- CFG_SKIP, in, SKIP_W, capture 1 frame in every CFG_SKIP+1 frames.
- PIX_DATA, out, BPP*DVP_W, assembled pixel; first byte in the MSBs.
- PIX_VALID, out, 1, PIX_DATA valid for one cycle.
- PIX_SOF, out, 1, qualifies the first window pixel of a frame.
- PIX_EOL, out, 1, qualifies the last window pixel of each row.
- FRAME_DONE, out, 1, one-cycle pulse at the end of a captured frame.
- LINE_ERR, out, 1, sticky odd-byte-line error.
- X_CONT, out, X_W, current sensor column, in pixels.
- Y_CONT, out, Y_W, current sensor row.
- FRAME_CNT, out, 16, count of captured frames; wraps at 16'hFFFF to 0.

Function
REQ-003 OV_DVP, OV_HREF and OV_VSYNC SHALL be registered once (stage s1); all logic SHALL use the s1 copies.
REQ-004 The frame start event (FS) SHALL be the s1 VSYNC falling edge; the frame end event (FE) SHALL be the s1 VSYNC rising edge.
REQ-005 The state machine SHALL have the states IDLE, ARM, CAPT and SKIP.
- IDLE -> ARM when CFG_EN=1.
- ARM at FS -> CAPT if the skip counter is 0, otherwise -> SKIP.
- CAPT or SKIP at FE -> ARM.
- Any state -> IDLE when CFG_EN=0 and s1 VSYNC=1.
REQ-006 At FS, CFG_X0/Y0/W/H SHALL be latched; config changes mid-frame SHALL have no effect.
REQ-007 The skip counter SHALL load CFG_SKIP at each FS where it is 0, and decrement at every other FS.
REQ-008 Byte phase SHALL reset to 0 whenever s1 HREF=0.
- With s1 HREF=1, phase counts 0..BPP-1 and wraps.
- The pixel completes on phase BPP-1.
REQ-009 X_CONT SHALL:
- increment after each completed pixel while s1 HREF=1;
- clear to 0 when s1 HREF=0.
REQ-010 Y_CONT SHALL:
- increment on each s1 HREF falling edge while s1 VSYNC=0;
- clear to 0 while s1 VSYNC=1.
REQ-011 A completed pixel is in-window when CFG_X0 <= X_CONT < CFG_X0+CFG_W and CFG_Y0 <= Y_CONT < CFG_Y0+CFG_H.
- Comparisons SHALL use X_W+1 / Y_W+1 bits so that the sums never wrap.
REQ-012 PIX_VALID SHALL pulse for exactly one cycle, registered, one cycle after the s1 cycle carrying the final byte (two OV_PCLK cycles after that byte is on OV_DVP), only for in-window pixels in state CAPT.
REQ-013 PIX_SOF SHALL be 1 with the first PIX_VALID of a CAPT frame and 0 otherwise.
REQ-014 PIX_EOL SHALL be 1 with PIX_VALID when X_CONT = CFG_X0+CFG_W-1.
REQ-015 PIX_DATA SHALL hold its last value when PIX_VALID=0.
REQ-016 FRAME_DONE SHALL pulse one cycle after FE when leaving CAPT with at least one pixel emitted; FRAME_CNT SHALL increment in the same cycle.
REQ-017 LINE_ERR SHALL set when s1 HREF falls with byte phase != 0 (BPP=2 only), and SHALL clear only on RST.
REQ-018 A line still active at FE SHALL be abandoned with no PIX_EOL; the next frame SHALL start from a clean state.
REQ-019 If CFG_EN falls during CAPT, the current frame SHALL complete; no new frame SHALL start.

Reset
REQ-020 On RST=1 at an OV_PCLK edge:
- state = IDLE;
- all counters, s1 registers, PIX_DATA and the skip counter = 0;
- all outputs = 0.
REQ-021 RST asserted mid-line SHALL suppress any pending PIX_VALID in the next cycle.
REQ-022 After reset, capture SHALL begin only at the next FS, never mid-frame.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- BPP=2, window 0,0,4,2; 6-pixel x 3-row frame, bytes 0x01,0x02... -> exactly 8 PIX_VALID; first PIX_DATA 16'h0102 with PIX_SOF; PIX_EOL on pixels 4 and 8; one FRAME_DONE; FRAME_CNT=1.
- Window X0=2,Y0=1,W=2,H=1 -> two pixels, taken from row 1 columns 2 and 3, the second with PIX_EOL.
- CFG_SKIP=2 over 6 frames -> FRAME_DONE after frames 1 and 4 only.
- Line with 7 HREF bytes (BPP=2) -> LINE_ERR=1, held across later good frames until RST.
- CFG_W changed mid-frame -> current frame uses the old width; the next frame uses the new width.
- RST mid-frame, then a partial frame -> no output until the following FS; FRAME_CNT restarts at 0.
